// File: rtl/sram_responder.sv
// Cycle-based model of a 16-bit asynchronous SRAM chip answering an SRAM controller.
// Configurable read latency, byte-lane masking, access counters and a bus-conflict flag.
module sram_responder #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 18,
    parameter int DEPTH_BITS    = 10,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    inout  wire  [DATA_WIDTH-1:0]    SRAM_DQ,
    input  logic [ADDRESS_WIDTH-1:0] SRAM_ADDR,
    input  logic                     SRAM_UB_N,
    input  logic                     SRAM_LB_N,
    input  logic                     SRAM_WE_N,
    input  logic                     SRAM_CE_N,
    input  logic                     SRAM_OE_N,
    output logic [15:0]              write_count,
    output logic [15:0]              read_count,
    output logic                     bus_conflict
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE} state_t;

    state_t                   state_reg, state_next;
    logic [2:0]               cnt_reg, cnt_next;
    logic [ADDRESS_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]    data_reg;
    logic [15:0]              write_count_reg, read_count_reg;
    logic                     bus_conflict_reg;
    logic                     load_data, enter_drive;

    logic [DATA_WIDTH-1:0]    mem [DEPTH] = '{default: '0};

    logic [DEPTH_BITS-1:0]    word_idx;
    logic [LANES-1:0]         lane_n;
    logic                     write_en, read_cond, conflict;

    assign word_idx  = SRAM_ADDR[DEPTH_BITS-1:0];
    assign lane_n    = {SRAM_UB_N, SRAM_LB_N};
    assign write_en  = !SRAM_CE_N && !SRAM_WE_N;
    assign read_cond = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
    assign conflict  = !SRAM_CE_N && !SRAM_WE_N && !SRAM_OE_N;

    // Byte-masked write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && write_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (!lane_n[i]) begin
                    mem[word_idx][i*8 +: 8] <= SRAM_DQ[i*8 +: 8];
                end
            end
        end
    end

    // Every data load happens while the live address equals the latched one
    // (or is being latched), so the array is always read at word_idx.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        addr_next   = addr_reg;
        load_data   = 1'b0;
        enter_drive = 1'b0;
        if (!read_cond) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_WAIT: begin
                    if (SRAM_ADDR != addr_reg) begin
                        addr_next = SRAM_ADDR;
                        if (READ_LATENCY == 1) begin
                            state_next  = S_DRIVE;
                            load_data   = 1'b1;
                            enter_drive = 1'b1;
                        end else begin
                            state_next = S_WAIT;
                            cnt_next   = CNT_LOAD;
                        end
                    end else if (cnt_reg == 3'd1) begin
                        state_next  = S_DRIVE;
                        load_data   = 1'b1;
                        enter_drive = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - 3'd1;
                    end
                end
                S_DRIVE: begin
                    if (SRAM_ADDR != addr_reg) begin
                        addr_next = SRAM_ADDR;
                        if (READ_LATENCY == 1) begin
                            state_next  = S_DRIVE;
                            load_data   = 1'b1;
                            enter_drive = 1'b1;
                        end else begin
                            state_next = S_WAIT;
                            cnt_next   = CNT_LOAD;
                        end
                    end else begin
                        load_data = 1'b1;
                    end
                end
                default: begin
                    addr_next = SRAM_ADDR;
                    if (READ_LATENCY == 1) begin
                        state_next  = S_DRIVE;
                        load_data   = 1'b1;
                        enter_drive = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            cnt_reg          <= 3'd0;
            addr_reg         <= '0;
            data_reg         <= '0;
            write_count_reg  <= 16'd0;
            read_count_reg   <= 16'd0;
            bus_conflict_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            addr_reg         <= addr_next;
            bus_conflict_reg <= conflict;
            if (load_data) begin
                data_reg <= mem[word_idx];
            end
            if (write_en && write_count_reg != 16'hFFFF) begin
                write_count_reg <= write_count_reg + 16'd1;
            end
            if (enter_drive && read_count_reg != 16'hFFFF) begin
                read_count_reg <= read_count_reg + 16'd1;
            end
        end
    end

    // Lane drive is combinational so a rising OE_N/CE_N/mask releases the bus at once.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign SRAM_DQ[gi*8 +: 8] = (state_reg == S_DRIVE && read_cond && !lane_n[gi])
                                        ? data_reg[gi*8 +: 8] : 8'bz;
        end
    endgenerate

    assign write_count  = write_count_reg;
    assign read_count   = read_count_reg;
    assign bus_conflict = bus_conflict_reg;
endmodule
